// File: rtl/cl_pack_pkg.sv
// Shared constants and state encoding for the CPU-to-DMA cache-line write packer.
package cl_pack_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 32;
  localparam int unsigned DEF_CL_WIDTH   = 512;
  localparam int unsigned WORDS_PER_CL   = DEF_CL_WIDTH / DEF_WORD_WIDTH;
  localparam int unsigned WCNT_WIDTH     = $clog2(WORDS_PER_CL);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    DONE
  } t_pack_state;

endpackage

// File: rtl/cl_out_reg.sv
// Cache-line holding register: loads a packed line and drains it to the DMA write FIFO.
module cl_out_reg #(
  parameter int unsigned Width = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             dma_full,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  output logic             out_wr_en
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_wr_en = valid_q && !dma_full;

  // A load in the same cycle as a drain keeps the register occupied with the new line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (out_wr_en) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_cl_write_packer.sv
// Packs the CPU's 32-bit word stream into zero-padded cache lines for the DMA write port.
module cpu_cl_write_packer
  import cl_pack_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int unsigned CL_WIDTH    = DEF_CL_WIDTH,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_words,
  output logic [COUNT_WIDTH-1:0] line_count,
  input  logic                   in_valid,
  input  logic [WORD_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  input  logic                   dma_full,
  output logic                   out_wr_en,
  output logic [CL_WIDTH-1:0]    out_data,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned WordsPerCl = CL_WIDTH / WORD_WIDTH;
  localparam int unsigned WcntWidth  = $clog2(WordsPerCl);

  t_pack_state          state_q;
  logic [WcntWidth-1:0] wcnt_q;
  logic [COUNT_WIDTH-1:0] total_q;
  logic [COUNT_WIDTH-1:0] num_words_q;
  logic [COUNT_WIDTH-1:0] line_count_q;
  logic [CL_WIDTH-1:0]  acc_q;
  logic [CL_WIDTH-1:0]  line_d;
  logic [COUNT_WIDTH:0] line_sum;
  logic                 accept;
  logic                 last_word;
  logic                 line_done;

  assign in_ready   = (state_q == BUSY) && !(out_valid && dma_full);
  assign accept     = in_valid && in_ready;
  assign last_word  = (total_q == num_words_q - COUNT_WIDTH'(1));
  assign line_done  = accept && (last_word || (wcnt_q == WcntWidth'(WordsPerCl - 1)));
  // One extra bit so num_words near the counter maximum cannot wrap the rounding add.
  assign line_sum   = {1'b0, num_words} + (COUNT_WIDTH + 1)'(WordsPerCl - 1);
  assign line_count = line_count_q;
  assign busy       = (state_q == BUSY) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

  // Accumulator with the incoming word merged at wcnt; slots above it are forced to zero.
  always_comb begin
    line_d = '0;
    for (int unsigned k = 0; k < WordsPerCl; k++) begin
      if (WcntWidth'(k) < wcnt_q) begin
        line_d[k*WORD_WIDTH +: WORD_WIDTH] = acc_q[k*WORD_WIDTH +: WORD_WIDTH];
      end else if (WcntWidth'(k) == wcnt_q) begin
        line_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      total_q      <= '0;
      num_words_q  <= '0;
      line_count_q <= '0;
      acc_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_words_q  <= num_words;
            line_count_q <= COUNT_WIDTH'(line_sum >> WcntWidth);
            wcnt_q       <= '0;
            total_q      <= '0;
            acc_q        <= '0;
            state_q      <= (num_words == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            total_q <= total_q + COUNT_WIDTH'(1);
            if (line_done) begin
              wcnt_q <= '0;
              acc_q  <= '0;
            end else begin
              wcnt_q <= wcnt_q + WcntWidth'(1);
              acc_q  <= line_d;
            end
            if (last_word) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!out_valid || out_wr_en) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cl_out_reg #(
    .Width(CL_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (line_done),
    .load_data(line_d),
    .dma_full (dma_full),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_wr_en(out_wr_en)
  );

endmodule

// File: tb/tb_cpu_cl_write_packer.sv
// Scoreboard bench for cpu_cl_write_packer: expected lines queued at start, popped on each strobe.
module tb_cpu_cl_write_packer;

  localparam int W   = 32;
  localparam int CL  = 512;
  localparam int CW  = 32;
  localparam int WPL = CL / W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [CW-1:0] line_count;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          dma_full = 1'b0;
  logic          out_wr_en;
  logic [CL-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  cpu_cl_write_packer #(
    .WORD_WIDTH (W),
    .CL_WIDTH   (CL),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .line_count(line_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dma_full  (dma_full),
    .out_wr_en (out_wr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  int            checks = 0;
  int            failures = 0;
  logic [CL-1:0] exp_q[$];
  logic [W-1:0]  wdata[64];
  int unsigned   cyc = 0;
  int unsigned   strobe_cnt = 0;
  int unsigned   last_strobe_cyc = 0;
  int unsigned   stall_cycles = 0;
  logic          stall_prev = 1'b0;
  logic [CL-1:0] held;
  logic [CL-1:0] exp_line;
  bit            feed_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and polices the stall behaviour.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_wr_en) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {{(CL-1){1'b0}}, out_wr_en}, '0);
        end else begin
          exp_line = exp_q.pop_front();
          check("line_data", out_data, exp_line);
        end
      end
      if (out_valid && dma_full) begin
        stall_cycles++;
        check("stall_no_strobe", {{(CL-1){1'b0}}, out_wr_en}, '0);
        check("stall_in_ready", {{(CL-1){1'b0}}, in_ready}, '0);
        if (stall_prev) check("stall_data_stable", out_data, held);
        held = out_data;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic int unsigned lines_for(input int unsigned n);
    return (n + WPL - 1) / WPL;
  endfunction

  task automatic build_expected(input int unsigned n);
    logic [CL-1:0] line;
    for (int unsigned l = 0; l < lines_for(n); l++) begin
      line = '0;
      for (int unsigned k = 0; k < WPL; k++) begin
        if (l * WPL + k < n) line[k*W +: W] = wdata[l*WPL+k];
      end
      exp_q.push_back(line);
    end
  endtask

  task automatic fill_seq(input int unsigned n, input logic [W-1:0] base);
    for (int unsigned i = 0; i < n; i++) wdata[i] = base + W'(i);
  endtask

  task automatic fill_rand(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) wdata[i] = $urandom;
  endtask

  task automatic start_xfer(input string name, input int unsigned n);
    strobe_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    num_words = n;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_line_count"}, line_count, lines_for(n));
    check({name, "_busy"}, {{(CL-1){1'b0}}, busy}, (n != 0));
    check({name, "_done"}, {{(CL-1){1'b0}}, done}, (n == 0));
    check({name, "_in_ready"}, {{(CL-1){1'b0}}, in_ready}, (n != 0));
  endtask

  task automatic feed(input int unsigned m, input bit gaps);
    logic rdy;
    int   budget;
    for (int unsigned i = 0; i < m; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = wdata[i];
      budget   = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        budget++;
      end while (!rdy && budget < 300);
      #1;
      if (!rdy) begin
        check("feed_timeout", {{(CL-1){1'b0}}, rdy}, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned n);
    int budget = 0;
    @(negedge clk);
    while (!done && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!done) begin
      check({name, "_done_timeout"}, {{(CL-1){1'b0}}, done}, 1);
    end else if (n != 0) begin
      check({name, "_done_latency"}, cyc, last_strobe_cyc + 1);
    end
    check({name, "_strobes"}, strobe_cnt, lines_for(n));
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_in_ready", {{(CL-1){1'b0}}, in_ready}, 0);
    check("rst_out_wr_en", {{(CL-1){1'b0}}, out_wr_en}, 0);
    check("rst_out_valid", {{(CL-1){1'b0}}, out_valid}, 0);
    check("rst_busy_done", {{(CL-2){1'b0}}, busy, done}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_line_count", line_count, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 16 words 0..15 back to back
    fill_seq(16, 32'h0);
    build_expected(16);
    start_xfer("t1", 16);
    feed(16, 1'b0);
    wait_done("t1", 16);

    // 20 words 1..20: second line zero-padded
    fill_seq(20, 32'h1);
    build_expected(20);
    start_xfer("t2", 20);
    feed(20, 1'b0);
    wait_done("t2", 20);

    // 48 words with the DMA full for 40 cycles after the first line
    fill_seq(48, 32'h1000);
    build_expected(48);
    stall_cycles = 0;
    start_xfer("t3", 48);
    fork
      feed(48, 1'b0);
      begin
        for (int c = 0; c < 300; c++) begin
          @(posedge clk);
          #1;
          if (out_valid) break;
        end
        dma_full = 1'b1;
        repeat (40) @(posedge clk);
        #1 dma_full = 1'b0;
      end
    join
    wait_done("t3", 48);
    check("t3_stalled", {{(CL-1){1'b0}}, (stall_cycles >= 39)}, 1);

    // Zero-length transfer
    start_xfer("t4", 0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_in_ready_low", {{(CL-1){1'b0}}, in_ready}, 0);
      check("t4_done_high", {{(CL-1){1'b0}}, done}, 1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("t4_strobes", strobe_cnt, 0);

    // Reset after 7 of 16 words, then a clean transfer
    fill_seq(16, 32'hA0);
    build_expected(16);
    start_xfer("t5a", 16);
    feed(7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", {{(CL-1){1'b0}}, in_ready}, 0);
    check("t5_rst_valid_strobe", {{(CL-2){1'b0}}, out_valid, out_wr_en}, 0);
    check("t5_rst_busy_done", {{(CL-2){1'b0}}, busy, done}, 0);
    check("t5_rst_out_data", out_data, 0);
    check("t5_rst_line_count", line_count, 0);
    exp_q.delete();
    strobe_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_strobe_after_reset", strobe_cnt, 0);
    fill_seq(16, 32'hB0);
    build_expected(16);
    start_xfer("t5b", 16);
    feed(16, 1'b0);
    wait_done("t5b", 16);

    // Start pulse mid-BUSY is ignored
    fill_seq(16, 32'h100);
    build_expected(16);
    start_xfer("t6a", 16);
    fork
      feed(16, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        num_words = 40;
        @(posedge clk);
        #1 start = 1'b0;
        check("t6_line_count_kept", line_count, 1);
        check("t6_still_busy", {{(CL-1){1'b0}}, busy}, 1);
      end
    join
    wait_done("t6a", 16);
    fill_seq(16, 32'h200);
    build_expected(16);
    start_xfer("t6b", 16);
    feed(16, 1'b0);
    wait_done("t6b", 16);

    // Randomized lengths, data, gaps and DMA back-pressure
    for (int it = 0; it < 6; it++) begin
      int unsigned n;
      n = $urandom_range(1, 64);
      fill_rand(n);
      build_expected(n);
      dma_full = 1'b0;
      start_xfer("rnd", n);
      feed_done = 1'b0;
      fork
        begin
          feed(n, 1'b1);
          feed_done = 1'b1;
        end
        begin
          while (!feed_done) begin
            @(posedge clk);
            #1 dma_full = ($urandom_range(0, 3) == 0);
          end
        end
      join
      dma_full = 1'b0;
      wait_done("rnd", n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
